// File: rtl/tx_sched.sv
// Two-source round-robin frame scheduler in front of a byte framer, with flag-filled inter-frame gaps.
// Data path is combinational from the granted source (zero latency); flow follows the framer's fr_consumed pulse.
module tx_sched (
  input  logic       netclk,
  input  logic       reset,
  input  logic       sched_en,
  input  logic       idle_fill,
  input  logic [3:0] gap_flags,
  input  logic [1:0] src_req,
  input  logic [7:0] src_data0,
  input  logic [7:0] src_data1,
  input  logic [1:0] src_avail,
  input  logic [1:0] src_eop,
  output logic [1:0] src_take,
  output logic [7:0] fr_data,
  output logic       fr_avail,
  output logic       fr_eop,
  input  logic       fr_consumed,
  output logic       fr_flag_fill,
  output logic       grant,
  output logic       busy,
  output logic [7:0] frames0,
  output logic [7:0] frames1,
  output logic       proto_err
);

  typedef enum logic [1:0] {IDLE, FRAME, GAP, HOLD} state_t;

  state_t     state_q, state_d;
  logic       grant_q, grant_d;
  logic [6:0] gap_cnt_q, gap_cnt_d;
  logic       drop_q, drop_d;
  logic [7:0] frames0_q, frames0_d;
  logic [7:0] frames1_q, frames1_d;
  logic       proto_err_q, proto_err_d;

  logic [7:0] g_data;
  logic       g_avail;
  logic       g_eop;
  logic       to_hold;

  always_comb begin
    g_data  = grant_q ? src_data1 : src_data0;
    g_avail = src_avail[grant_q];
    g_eop   = src_eop[grant_q];
    // an enable drop seen at any point of the frame or gap diverts the exit to HOLD
    to_hold = drop_q | ~sched_en;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gap_cnt_d    = gap_cnt_q;
    drop_d       = drop_q;
    frames0_d    = frames0_q;
    frames1_d    = frames1_q;
    proto_err_d  = proto_err_q;
    src_take     = 2'b00;
    fr_data      = 8'h00;
    fr_avail     = 1'b0;
    fr_eop       = 1'b0;
    fr_flag_fill = idle_fill;

    unique case (state_q)
      IDLE: begin
        if (fr_consumed) proto_err_d = 1'b1;
        if (sched_en && (src_req != 2'b00)) begin
          state_d = FRAME;
          grant_d = (src_req == 2'b11) ? ~grant_q : src_req[1];
          drop_d  = 1'b0;
        end
      end
      FRAME: begin
        fr_flag_fill = 1'b0;
        fr_data      = g_data;
        fr_eop       = g_eop;
        fr_avail     = g_avail | g_eop;
        if (!sched_en) drop_d = 1'b1;
        if (fr_consumed && !(g_avail | g_eop)) proto_err_d = 1'b1;
        if (fr_consumed && g_avail && !g_eop) src_take = grant_q ? 2'b10 : 2'b01;
        if (fr_consumed && g_eop) begin
          if (grant_q) frames1_d = frames1_q + 8'd1;
          else         frames0_d = frames0_q + 8'd1;
          gap_cnt_d = {gap_flags, 3'b000};
          if (gap_flags == 4'd0) begin
            state_d = to_hold ? HOLD : IDLE;
            drop_d  = 1'b0;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        fr_flag_fill = 1'b1;
        if (fr_consumed) proto_err_d = 1'b1;
        if (!sched_en) drop_d = 1'b1;
        gap_cnt_d = gap_cnt_q - 7'd1;
        if (gap_cnt_q == 7'd1) begin
          state_d = to_hold ? HOLD : IDLE;
          drop_d  = 1'b0;
        end
      end
      HOLD: begin
        if (fr_consumed) proto_err_d = 1'b1;
        if (sched_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge netclk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      grant_q     <= 1'b1;
      gap_cnt_q   <= 7'd0;
      drop_q      <= 1'b0;
      frames0_q   <= 8'd0;
      frames1_q   <= 8'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gap_cnt_q   <= gap_cnt_d;
      drop_q      <= drop_d;
      frames0_q   <= frames0_d;
      frames1_q   <= frames1_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q == FRAME) || (state_q == GAP);
  assign frames0   = frames0_q;
  assign frames1   = frames1_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_tx_sched.sv
// Randomized bench for tx_sched: frame-level source/framer reference model feeding an output scoreboard.
`timescale 1ns/1ps
module tb_tx_sched;

  logic       netclk = 1'b0;
  logic       reset;
  logic       sched_en, idle_fill, fr_consumed;
  logic [3:0] gap_flags;
  logic [1:0] src_req, src_avail, src_eop, src_take;
  logic [7:0] src_data0, src_data1, fr_data, frames0, frames1;
  logic       fr_avail, fr_eop, fr_flag_fill, grant, busy, proto_err;

  always #5 netclk = ~netclk;

  tx_sched dut (
    .netclk(netclk), .reset(reset), .sched_en(sched_en), .idle_fill(idle_fill),
    .gap_flags(gap_flags), .src_req(src_req), .src_data0(src_data0), .src_data1(src_data1),
    .src_avail(src_avail), .src_eop(src_eop), .src_take(src_take), .fr_data(fr_data),
    .fr_avail(fr_avail), .fr_eop(fr_eop), .fr_consumed(fr_consumed), .fr_flag_fill(fr_flag_fill),
    .grant(grant), .busy(busy), .frames0(frames0), .frames1(frames1), .proto_err(proto_err)
  );

  typedef struct packed {
    logic [1:0] take;
    logic [7:0] data;
    logic       avail;
    logic       eop;
    logic       fill;
    logic       grant;
    logic       busy;
    logic [7:0] f0;
    logic [7:0] f1;
    logic       perr;
  } out_t;
  typedef struct { int cyc; out_t o; } exp_t;

  localparam int S_IDLE = 0, S_FRAME = 1, S_GAP = 2, S_HOLD = 3;

  int   n_vec = 0, n_err = 0, cyc = 0;
  exp_t exp_q[$];
  int   gr_log[$];
  int   n_take0 = 0, n_take1 = 0, n_gap = 0, f1_max = 0;

  bit k_rst = 0, k_en = 0, k_drop = 0, k_gap_rand = 0, k_en_rand = 0, k_force_cons = 0;
  int k_gap = 0, k_pav = 100, k_pcons = 100, k_pnew = 0;

  // reference model: scheduler mode, owner, remaining gap cycles, per-source frame counts
  int m_st, m_gap;
  bit m_g, m_drop, m_perr;
  int m_fr[2];
  // what was applied during the last cycle, consumed at the next edge
  bit         p_run = 0, p_en = 0, p_cons = 0, p_end = 0;
  logic [1:0] p_req, p_take;
  int         p_gf;

  // source model: pending frames as byte queues plus frame lengths
  logic [7:0] qb0[$], qb1[$];
  int         ql0[$], ql1[$];
  int         rem[2];

  function automatic int qlen(input int i);
    return (i == 0) ? ql0.size() : ql1.size();
  endfunction
  function automatic int head(input int i);
    if (qlen(i) == 0) return 0;
    return (i == 0) ? ql0[0] : ql1[0];
  endfunction
  function automatic logic [7:0] fbyte(input int i);
    return (i == 0) ? qb0[0] : qb1[0];
  endfunction

  task automatic add_frame(input int i, input int len);
    if (qlen(i) == 0) rem[i] = len;
    for (int b = 0; b < len; b++) begin
      if (i == 0) qb0.push_back(8'($urandom)); else qb1.push_back(8'($urandom));
    end
    if (i == 0) ql0.push_back(len); else ql1.push_back(len);
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_g = 1'b1; m_gap = 0; m_drop = 0; m_perr = 0;
    m_fr[0] = 0; m_fr[1] = 0;
    qb0.delete(); qb1.delete(); ql0.delete(); ql1.delete();
    rem[0] = 0; rem[1] = 0;
    p_take = 2'b00; p_end = 0;
  endtask

  task automatic model_edge();
    bit leave_hold;
    for (int i = 0; i < 2; i++) if (p_take[i]) begin
      if (i == 0) void'(qb0.pop_front()); else void'(qb1.pop_front());
      rem[i]--;
    end
    if (p_end) begin
      if (m_g == 0) void'(ql0.pop_front()); else void'(ql1.pop_front());
      rem[m_g] = head(int'(m_g));
    end
    leave_hold = m_drop || !p_en;
    case (m_st)
      S_IDLE: begin
        if (p_cons) m_perr = 1;
        if (p_en && p_req != 2'b00) begin
          m_g = (p_req == 2'b11) ? !m_g : p_req[1];
          m_st = S_FRAME; m_drop = 0;
        end
      end
      S_FRAME: begin
        m_drop = leave_hold;
        if (p_cons && !p_end && !p_take[m_g]) m_perr = 1;
        if (p_end) begin
          m_fr[m_g] = (m_fr[m_g] + 1) % 256;
          if (p_gf == 0) begin m_st = leave_hold ? S_HOLD : S_IDLE; m_drop = 0; end
          else begin m_st = S_GAP; m_gap = p_gf * 8; end
        end
      end
      S_GAP: begin
        if (p_cons) m_perr = 1;
        m_drop = leave_hold;
        m_gap--;
        if (m_gap == 0) begin m_st = leave_hold ? S_HOLD : S_IDLE; m_drop = 0; end
      end
      default: begin
        if (p_cons) m_perr = 1;
        if (p_en) m_st = S_IDLE;
      end
    endcase
  endtask

  task automatic step();
    logic [1:0] rq, av, eo;
    logic [7:0] d0, d1;
    bit   cons, fill;
    int   gap;
    out_t e;
    exp_t r;
    @(posedge netclk); #1;
    cyc++;
    if (p_run) model_edge();
    if (!k_rst) model_reset();
    if (k_en_rand && $urandom_range(0, 99) < 3) k_en = !k_en;
    if (k_pnew > 0)
      for (int i = 0; i < 2; i++)
        if (qlen(i) < 2 && $urandom_range(0, 99) < k_pnew) add_frame(i, $urandom_range(1, 5));
    d0 = 8'h00; d1 = 8'h00;
    for (int i = 0; i < 2; i++) begin
      bit has, started;
      logic [7:0] d;
      has     = qlen(i) > 0;
      started = has && (rem[i] < head(i));
      eo[i]   = has && (rem[i] == 0);
      av[i]   = has && (rem[i] > 0) && ($urandom_range(0, 99) < k_pav);
      d       = av[i] ? fbyte(i) : 8'($urandom);
      if (i == 0) d0 = d; else d1 = d;
      rq[i]   = has && !(k_drop && started && $urandom_range(0, 3) == 0);
    end
    gap  = k_gap_rand ? $urandom_range(0, 3) : k_gap;
    fill = 1'($urandom_range(0, 1));
    e = '0;
    e.grant = m_g; e.busy = (m_st == S_FRAME) || (m_st == S_GAP);
    e.f0 = 8'(m_fr[0]); e.f1 = 8'(m_fr[1]); e.perr = m_perr; e.fill = fill;
    if (m_st == S_FRAME) begin
      e.data = m_g ? d1 : d0; e.eop = eo[m_g]; e.avail = av[m_g] | eo[m_g]; e.fill = 1'b0;
    end else if (m_st == S_GAP) begin
      e.fill = 1'b1;
    end
    cons = k_force_cons || (m_st == S_FRAME && e.avail && $urandom_range(0, 99) < k_pcons);
    p_take = 2'b00;
    if (m_st == S_FRAME && cons && av[m_g] && !eo[m_g]) p_take[m_g] = 1'b1;
    e.take = p_take;
    p_end  = (m_st == S_FRAME) && cons && eo[m_g];
    p_req = rq; p_en = k_en; p_cons = cons; p_gf = gap; p_run = k_rst;
    reset = k_rst; sched_en = k_en; idle_fill = fill; gap_flags = 4'(gap);
    src_req = rq; src_avail = av; src_eop = eo; src_data0 = d0; src_data1 = d1;
    fr_consumed = cons;
    r.cyc = cyc; r.o = e;
    exp_q.push_back(r);
  endtask

  task automatic sample();
    @(negedge netclk); #1;
  endtask

  task automatic chk(input string nm, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    end
  endtask

  task automatic wait_st(input int st, input int budget, input string nm);
    int n = 0;
    while (m_st != st && n < budget) begin step(); n++; end
    chk({nm, "_reached"}, int'(m_st == st), 1);
  endtask

  task automatic drain(input int budget, input string nm);
    int n = 0;
    while (!(m_st == S_IDLE && qlen(0) == 0 && qlen(1) == 0) && n < budget) begin step(); n++; end
    chk({nm, "_drained"}, int'(m_st == S_IDLE && qlen(0) == 0 && qlen(1) == 0), 1);
  endtask

  // monitor: pops one expected record per presented cycle and tracks observed events
  initial begin
    exp_t r;
    out_t a;
    bit   pb;
    pb = 0;
    forever begin
      @(negedge netclk);
      a.take = src_take; a.data = fr_data; a.avail = fr_avail; a.eop = fr_eop;
      a.fill = fr_flag_fill; a.grant = grant; a.busy = busy;
      a.f0 = frames0; a.f1 = frames1; a.perr = proto_err;
      if (busy && !pb) gr_log.push_back(int'(grant));
      pb = busy;
      if (src_take[0]) n_take0++;
      if (src_take[1]) n_take1++;
      if (busy && fr_flag_fill) n_gap++;
      if (int'(frames1) > f1_max) f1_max = int'(frames1);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        n_vec++;
        if (r.cyc != cyc || a !== r.o) begin
          n_err++;
          $display("FAIL outputs cyc=%0d/%0d: got take=%b data=%h avail=%b eop=%b fill=%b grant=%b busy=%b f0=%0d f1=%0d perr=%b, expected take=%b data=%h avail=%b eop=%b fill=%b grant=%b busy=%b f0=%0d f1=%0d perr=%b",
                   cyc, r.cyc, a.take, a.data, a.avail, a.eop, a.fill, a.grant, a.busy, a.f0, a.f1, a.perr,
                   r.o.take, r.o.data, r.o.avail, r.o.eop, r.o.fill, r.o.grant, r.o.busy, r.o.f0, r.o.f1, r.o.perr);
        end
      end
    end
  end

  initial begin
    int want_gr[4];
    want_gr[0] = 0; want_gr[1] = 1; want_gr[2] = 0; want_gr[3] = 1;
    reset = 1'b0; sched_en = 0; idle_fill = 0; gap_flags = 0; src_req = 0;
    src_avail = 0; src_eop = 0; src_data0 = 0; src_data1 = 0; fr_consumed = 0;
    model_reset();

    // reset state
    repeat (3) step();
    sample();
    chk("rst_grant", grant, 1); chk("rst_busy", busy, 0); chk("rst_perr", proto_err, 0);
    chk("rst_frames0", frames0, 0); chk("rst_frames1", frames1, 0);
    chk("rst_fill", fr_flag_fill, idle_fill); chk("rst_avail", fr_avail, 0);
    k_rst = 1; k_en = 1;
    step();

    // contention: both sources request, no gap
    gr_log.delete();
    add_frame(0, 2); add_frame(0, 3); add_frame(1, 1); add_frame(1, 4);
    drain(400, "contention");
    sample();
    chk("contention_frames0", frames0, 2); chk("contention_frames1", frames1, 2);
    chk("contention_ngrants", gr_log.size(), 4);
    for (int k = 0; k < 4 && k < gr_log.size(); k++) chk("contention_grant_order", gr_log[k], want_gr[k]);

    // single three-byte frame with a two-flag gap
    n_take0 = 0; n_take1 = 0; n_gap = 0;
    k_gap = 2;
    add_frame(0, 3);
    drain(200, "single");
    sample();
    chk("single_takes0", n_take0, 3); chk("single_takes1", n_take1, 0);
    chk("single_frames0", frames0, 3); chk("single_gap_cycles", n_gap, 16);
    chk("single_idle_busy", busy, 0);

    // enable drop mid-frame, then hold with a new request pending
    k_gap = 1; k_pcons = 50;
    add_frame(1, 6);
    wait_st(S_FRAME, 20, "drop_frame");
    step(); step();
    k_en = 0;
    wait_st(S_HOLD, 300, "drop_hold");
    add_frame(0, 2);
    repeat (20) step();
    sample();
    chk("hold_busy", busy, 0); chk("hold_avail", fr_avail, 0);
    chk("hold_frames1", frames1, 3); chk("hold_frames0", frames0, 3);
    k_en = 1; k_pcons = 100;
    drain(200, "resume");
    sample();
    chk("resume_frames0", frames0, 4);

    // framer pulse while idle
    n_take0 = 0; n_take1 = 0;
    sample();
    chk("perr_before", proto_err, 0);
    k_force_cons = 1; step(); k_force_cons = 0; step();
    sample();
    chk("perr_idle", proto_err, 1); chk("perr_idle_takes", n_take0 + n_take1, 0);
    chk("perr_idle_frames0", frames0, 4); chk("perr_idle_frames1", frames1, 3);

    // randomized traffic with enable toggling, stalls and random gaps
    k_pnew = 25; k_gap_rand = 1; k_pav = 70; k_pcons = 70; k_drop = 1; k_en_rand = 1;
    repeat (3000) step();
    k_pnew = 0; k_en_rand = 0; k_en = 1;
    drain(2000, "random");

    // wrap of the source-1 counter
    k_rst = 0; step(); step(); k_rst = 1; step();
    k_gap_rand = 0; k_gap = 0; k_pav = 100; k_pcons = 100; k_drop = 0; f1_max = 0;
    for (int f = 0; f < 256; f++) add_frame(1, 1);
    drain(4000, "wrap");
    sample();
    chk("wrap_max", f1_max, 255); chk("wrap_frames1", frames1, 0); chk("wrap_frames0", frames0, 0);

    // consume without a valid byte, then reset mid-frame
    k_pav = 0; k_pcons = 0;
    add_frame(1, 3);
    wait_st(S_FRAME, 10, "bad_frame");
    n_take0 = 0; n_take1 = 0;
    k_force_cons = 1; step(); k_force_cons = 0; step();
    sample();
    chk("perr_frame", proto_err, 1); chk("perr_frame_takes", n_take0 + n_take1, 0);
    k_pav = 100; k_pcons = 100;
    step(); step();
    k_rst = 0; k_force_cons = 1; step();
    sample();
    chk("midrst_busy", busy, 0); chk("midrst_grant", grant, 1); chk("midrst_perr", proto_err, 0);
    chk("midrst_frames1", frames1, 0); chk("midrst_take", src_take, 0);
    chk("midrst_avail", fr_avail, 0); chk("midrst_data", fr_data, 0);
    chk("midrst_fill", fr_flag_fill, idle_fill);
    k_force_cons = 0; step(); k_rst = 1; step();
    add_frame(0, 2);
    drain(100, "post_reset");
    sample();
    chk("post_reset_frames0", frames0, 1); chk("post_reset_frames1", frames1, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
